// File: rtl/ascon_sigma_seq.sv
// Multi-cycle Ascon sigma unit: res = x ^ (x >>> r0) ^ (x >>> r1) on a 64-bit lane,
// with configurable rotate stages per cycle and a single-entry result cache.
module ascon_sigma_seq #(
    parameter int STAGES_PER_CYC = 2,
    parameter bit CACHE_EN       = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  imm,
    input  logic        op_sigma_lo,
    input  logic        op_sigma_hi,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rd
);
    localparam int N  = 6 / STAGES_PER_CYC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t         state_q;
    logic [63:0]    x_q, w0_q, w1_q, res_q;
    logic [4:0]     imm_q;
    logic           lo_q, hi_q;
    logic [68:0]    tag_q;
    logic           cvld_q;
    logic [CW-1:0]  cnt_q;
    logic           rsp_valid_q;
    logic [31:0]    rd_q;

    logic [11:0]    amt;
    logic [63:0]    w0_d, w1_d, res_d;
    logic           last, hit;

    // Returns {r1, r0}; unused indices rotate by zero so res collapses to x.
    function automatic logic [11:0] amounts(input logic [4:0] i);
        case (i)
            5'd0:    return {6'd28, 6'd19};
            5'd1:    return {6'd39, 6'd61};
            5'd2:    return {6'd6,  6'd1};
            5'd3:    return {6'd17, 6'd10};
            5'd4:    return {6'd41, 6'd7};
            default: return 12'd0;
        endcase
    endfunction

    // Stage k belongs to iteration cycle k / STAGES_PER_CYC.
    function automatic logic [63:0] rot_step(input logic [63:0] w, input logic [5:0] a,
                                             input int cyc);
        logic [63:0] r;
        r = w;
        for (int k = 0; k < 6; k++)
            if ((k / STAGES_PER_CYC) == cyc && a[k])
                r = (r >> (1 << k)) | (r << (64 - (1 << k)));
        return r;
    endfunction

    function automatic logic [31:0] sel(input logic [63:0] r, input logic l, input logic h);
        return ({32{l}} & r[31:0]) | ({32{h}} & r[63:32]);
    endfunction

    always_comb begin
        amt   = amounts(imm_q);
        w0_d  = rot_step(w0_q, amt[5:0],  int'(cnt_q));
        w1_d  = rot_step(w1_q, amt[11:6], int'(cnt_q));
        res_d = x_q ^ w0_d ^ w1_d;
        last  = (cnt_q == CW'(N - 1));
        hit   = CACHE_EN && cvld_q && (tag_q == {rs2, rs1, imm});
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q     <= IDLE;
            cvld_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rd_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    x_q   <= {rs2, rs1};
                    imm_q <= imm;
                    lo_q  <= op_sigma_lo;
                    hi_q  <= op_sigma_hi;
                    if (hit) begin
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rd_q        <= sel(res_q, op_sigma_lo, op_sigma_hi);
                    end else begin
                        w0_q    <= {rs2, rs1};
                        w1_q    <= {rs2, rs1};
                        cnt_q   <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    w0_q  <= w0_d;
                    w1_q  <= w1_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        res_q       <= res_d;
                        tag_q       <= {x_q, imm_q};
                        cvld_q      <= 1'b1;
                        state_q     <= DONE;
                        rsp_valid_q <= 1'b1;
                        rd_q        <= sel(res_d, lo_q, hi_q);
                    end
                end
                DONE: if (rsp_ready) begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rd_q        <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rd        = rd_q;
endmodule
